div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 109 ++++++++++
 tb/tb_div_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero bypass and a one-cycle result strobe.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             validOut,
  output logic             divByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;

  logic             sgn_op, sign_a, sign_b, zero_div;
  logic [WIDTH-1:0] rem, quo, dvs;

  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic             accept;

  // Magnitude of a two's complement value; passes the value through in unsigned mode.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (en && sv < 0) ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  assign accept = (state == IDLE) && validIn;
  assign busy   = (state != IDLE);

  // Restoring step: the partial remainder is always below the divisor, so the
  // MSB of the W+1-bit difference is a clean borrow flag.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign fits    = ~trial[WIDTH];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (validIn) state_next = (SrcB == '0) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      validOut  <= 1'b0;
      divByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      state    <= state_next;
      validOut <= (state == DONE);
      if (accept)
        cnt <= CNT_W'(WIDTH);
      else if (state == CALC)
        cnt <= cnt - CNT_W'(1);
      if (state == DONE) begin
        divByZero <= zero_div;
        if (zero_div) begin
          Hi <= quo;
          Lo <= '1;
        end else begin
          Hi <= apply_sign(rem, sgn_op & sign_a);
          Lo <= apply_sign(quo, sgn_op & (sign_a ^ sign_b));
        end
      end
    end
  end

  // Working registers carry no reset; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      sgn_op   <= signedOp;
      sign_a   <= SrcA[WIDTH-1];
      sign_b   <= SrcB[WIDTH-1];
      zero_div <= (SrcB == '0);
      dvs      <= magnitude(SrcB, signedOp);
      rem      <= '0;
      quo      <= (SrcB == '0) ? SrcA : magnitude(SrcA, signedOp);
    end else if (state == CALC) begin
      rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH=32): arithmetic reference model with a
// per-cycle compare, plus hand-computed literal expectations.
module tb_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         validIn = 1'b0;
  logic         signedOp = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         busy, validOut, divByZero;
  logic [W-1:0] Hi, Lo;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .signedOp(signedOp),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .validOut(validOut),
    .divByZero(divByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {divByZero, Hi, Lo} from plain integer arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == '0) return {1'b1, a, {W{1'b1}}};
    if (!s) return {1'b0, a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {1'b0, rv[W-1:0], qv[W-1:0]};
  endfunction

  // Transaction-level model: accept when not pending, deliver after a fixed latency.
  bit           pending = 1'b0;
  longint       edge_n = 0, due = 0;
  logic [2*W:0] res;
  logic         exp_busy = 1'b0, exp_vld = 1'b0, exp_dbz = 1'b0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pending = 1'b0; exp_busy = 1'b0; exp_vld = 1'b0;
      exp_dbz = 1'b0; exp_hi = '0; exp_lo = '0;
    end else begin
      edge_n++;
      exp_vld = 1'b0;
      if (pending) begin
        if (edge_n == due) begin
          {exp_dbz, exp_hi, exp_lo} = res;
          exp_vld = 1'b1;
          pending = 1'b0;
        end
      end else if (validIn) begin
        res     = ref_div(SrcA, SrcB, signedOp);
        due     = edge_n + ((SrcB == '0) ? 1 : W + 1);
        pending = 1'b1;
      end
      exp_busy = pending;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", busy, exp_busy);
      check("validOut", validOut, exp_vld);
      check("divByZero", divByZero, exp_dbz);
      check("Hi", Hi, exp_hi);
      check("Lo", Lo, exp_lo);
    end
  end

  // Present an operation for one edge, then scramble the operands.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    SrcA = a; SrcB = b; signedOp = s; validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    SrcA = $urandom; SrcB = $urandom; signedOp = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (!validOut && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!validOut) begin
      checks++;
      errors++;
      $display("FAIL timeout: validOut not seen within %0d cycles", n);
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] lo, hi;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[6];
  int   n;

  initial begin
    vecs[0] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[1] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0, 33};
    vecs[2] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[3] = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        1'b0, 33};
    vecs[4] = '{32'hFFFFFF9C, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1};
    vecs[5] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        1'b0, 33};

    started = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_Lo", Lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 412/412 unsigned
    start_op(32'd412, 32'd412, 1'b0);
    check("accept_busy", busy, 1'b1);
    wait_vld(n);
    check("lat_412", n, 33);
    check("lo_412", Lo, 32'd1);
    check("hi_412", Hi, 32'd0);
    check("dbz_412", divByZero, 1'b0);

    // Back-to-back: unsigned then signed 0xFFFFFFF9 / 2
    @(negedge clk);
    start_op(32'hFFFFFFF9, 32'd2, 1'b0);
    wait_vld(n);
    check("lo_u7", Lo, 32'h7FFFFFFC);
    check("hi_u7", Hi, 32'd1);
    start_op(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_vld(n);
    check("lat_b2b", n, 33);
    check("lo_s7", Lo, 32'hFFFFFFFD);
    check("hi_s7", Hi, 32'hFFFFFFFF);

    // Signed overflow
    @(negedge clk);
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_vld(n);
    check("lo_ovf", Lo, 32'h80000000);
    check("hi_ovf", Hi, 32'd0);
    check("dbz_ovf", divByZero, 1'b0);

    // Divide by zero, both modes
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      start_op(32'd100, 32'd0, 1'(m));
      wait_vld(n);
      check("lat_dbz", n, 1);
      check("dbz_flag", divByZero, 1'b1);
      check("lo_dbz", Lo, 32'hFFFFFFFF);
      check("hi_dbz", Hi, 32'd100);
      @(negedge clk);
      check("dbz_hold", divByZero, 1'b1);
    end

    foreach (vecs[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_vld(n);
      check("vec_lat", n, vecs[i].lat);
      check("vec_lo", Lo, vecs[i].lo);
      check("vec_hi", Hi, vecs[i].hi);
      check("vec_dbz", divByZero, vecs[i].dbz);
    end

    // validIn held high with operands changed during CALC
    @(negedge clk);
    SrcA = 32'd100; SrcB = 32'd7; signedOp = 1'b0; validIn = 1'b1;
    @(negedge clk);
    SrcA = 32'd5; SrcB = 32'd5;
    wait_vld(n);
    check("lat_held", n, 33);
    check("lo_held", Lo, 32'd14);
    check("hi_held", Hi, 32'd2);
    @(negedge clk);
    validIn = 1'b0;
    check("held_reaccept", busy, 1'b1);
    wait_vld(n);
    check("lo_5_5", Lo, 32'd1);
    check("hi_5_5", Hi, 32'd0);

    // Reset mid-operation, then a fresh operation right after release
    @(negedge clk);
    start_op(32'h12345678, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_vld", validOut, 1'b0);
    check("mid_rst_lo", Lo, 32'd0);
    check("mid_rst_hi", Hi, 32'd0);
    check("mid_rst_dbz", divByZero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start_op(32'd9, 32'd3, 1'b0);
    wait_vld(n);
    check("lat_9_3", n, 33);
    check("lo_9_3", Lo, 32'd3);
    check("hi_9_3", Hi, 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
